// File: rtl/des_key_schedule_if.sv
// Handshake and data signals between the DES key schedule and its consumer.
// The master side loads keys and requests steps; the slave side presents round keys.
interface des_key_schedule_if;
    logic        key_load;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_next;
    logic [47:0] round_key;
    logic        round_key_valid;
    logic [3:0]  round_num;
    logic        done;

    modport master (
        output key_load, key_in, decrypt, key_next,
        input  round_key, round_key_valid, round_num, done
    );

    modport slave (
        input  key_load, key_in, decrypt, key_next,
        output round_key, round_key_valid, round_num, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, per-step C/D rotation, combinational PC-2.
// Encrypt walks K1..K16 with left rotations, decrypt walks K16..K1 with right rotations.
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_schedule_if.slave    ks
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;

    logic [55:0] pc1_cd;
    logic [55:0] cd_cur;
    logic [47:0] pc2_key;
    logic [1:0]  shamt;

    function automatic logic [1:0] shift_of(input logic [4:0] r);
        return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // DES bit n maps to vector bit (width - n) on both sides of each table.
    always_comb begin
        pc1_cd = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            pc1_cd[6'(55 - i)] = ks.key_in[6'(64 - PC1[i])];
        end
    end

    assign cd_cur = {c_q, d_q};

    always_comb begin
        pc2_key = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            pc2_key[6'(47 - i)] = cd_cur[6'(56 - PC2[i])];
        end
    end

    // Encrypt step k->k+1 uses s(k+2); decrypt step k->k+1 undoes s(16-k).
    always_comb begin
        shamt = mode_q ? shift_of(5'd16 - {1'b0, round_q})
                       : shift_of({1'b0, round_q} + 5'd2);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (ks.key_load) begin
            c_d     = ks.decrypt ? pc1_cd[55:28] : rotl(pc1_cd[55:28], 2'd1);
            d_d     = ks.decrypt ? pc1_cd[27:0]  : rotl(pc1_cd[27:0], 2'd1);
            mode_d  = ks.decrypt;
            round_d = '0;
            state_d = ACTIVE;
        end else if (ks.key_next && state_q == ACTIVE) begin
            if (round_q == 4'(NUM_ROUNDS - 1)) begin
                state_d = IDLE;
                round_d = '0;
                done_d  = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
                c_d     = mode_q ? rotr(c_q, shamt) : rotl(c_q, shamt);
                d_d     = mode_q ? rotr(d_q, shamt) : rotl(d_q, shamt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign ks.round_key       = pc2_key;
    assign ks.round_key_valid = (state_q == ACTIVE);
    assign ks.round_num       = round_q;
    assign ks.done            = done_q;
endmodule
